pipelined_adder: RTL
====================

# pipelined_adder

Parametrised, pipelined ripple-carry adder: WIDTH-bit operands are added CHUNK bits per pipeline stage, with the carry registered between stages. It accepts one operation per clock and returns results in order after a fixed latency, with a valid/ready handshake on each side. It is the sequential, width-generic successor to the team's fixed 16-bit combinational ripple-carry adder, for datapaths where a full-width ripple does not close timing.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of CHUNK (elaboration error otherwise)
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK
- clk  input  1  rising-edge clock (only clock)
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a, b  input  WIDTH  operands
- cin  input  1  carry-in to bit 0
- sub  input  1  subtract select (present only with PIPE_ADD_SUB_EN)
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1

## Operation
- Input accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of a, b plus the carry from stage k-1 (stage 0 uses cin); stores the chunk sum and its carry-out.
- Higher operand chunks travel alongside in skew registers until their stage; completed lower sum chunks travel in deskew registers, so sum is fully aligned at the last stage.
- Each stage holds a valid bit; data moves in lockstep under a single enable en = !out_valid || out_ready. in_ready = en.
- On stall (out_valid && !out_ready): every register, including valid bits, holds; sum/cout/out_valid stable until accepted.
- Bubbles (in_valid low while en) propagate as invalid slots; they are not collapsed.
- Arithmetic: {cout, sum} = a + b + cin, exact modulo 2^(WIDTH+1); no overflow flag.
- Results leave in acceptance order.

## Timing
- Reset (rst high at clk edge): all valid bits 0, out_valid 0, sum 0, cout 0, all skew/deskew and carry registers 0; in_ready is 1 in the cycle after reset. rst overrides any handshake in the same cycle; in-flight beats are discarded.
- Latency: beat accepted at edge N appears with out_valid high after edge N+STAGES (STAGES=4 default), absent stalls.
- Throughput: one beat per clock while out_ready stays high.
- Simultaneous accept and output transfer in the same cycle is legal and required at full rate.
- Back-pressure: out_ready low with out_valid high drops in_ready combinationally in the same cycle; no beat is lost or duplicated.
- out_valid low: in_ready high regardless of out_ready (empty slot at output absorbs).
- CHUNK = WIDTH: single stage, latency 1.

## Configuration
- PIPE_ADD_SUB_EN defined: sub port exists; sub is sampled with a, b and staged. sub=1 computes a + ~b + ~cin, i.e. a - b - cin (cin acts as borrow-in); cout is the raw carry (1 = no borrow). sub=0 behaves as plain add.
- Not defined: no sub port; add only; no inversion logic.

## Test plan
- Reset then single beat: a=16'h1234, b=16'h4321, cin=0 -> after 4 cycles out_valid=1, sum=16'h5555, cout=0.
- Full carry ripple across all stages: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
- Back-to-back 8 beats with out_ready=1, a=i, b=2*i -> one result per clock, sum=3*i in order, in_ready never low.
- Stall: out_ready low for 5 cycles with pipe full -> in_ready low, sum/cout frozen, no loss; release -> remaining beats drain in order.
- rst asserted mid-stream with 3 beats in flight -> next cycle out_valid=0, sum=0, cout=0; no stale beat later emerges.
- With PIPE_ADD_SUB_EN: a=16'h0005, b=16'h0007, cin=0, sub=1 -> sum=16'hFFFE, cout=0; a=16'h0009, b=16'h0003, sub=1 -> sum=16'h0006, cout=1.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder
//
// Width-generic pipelined ripple-carry adder. Each of STAGES = WIDTH/CHUNK
// stages adds one CHUNK-bit slice, and the carry is registered between
// stages. Operand bits that are still to be added ride forward in skew
// registers. Finished low sum slices ride forward in deskew registers, so
// the full-width result lines up at the output register.
//
// One beat is accepted per clock. Results leave in order. A beat accepted
// at edge N is presented after edge N+STAGES. The whole pipe advances on a
// single enable, so a stall freezes every register, including the valid
// bits.
//
// Optional feature macro: PIPE_ADD_SUB_EN
//   When it is defined, the sub port exists. sub=1 computes a + ~b + ~cin,
//   that is a - b - cin, where cin acts as borrow-in and cout=1 means no
//   borrow.
//
// Parameters:
//   WIDTH      operand/result width; must be a positive multiple of CHUNK
//   CHUNK      bits added per stage
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   block can accept a beat this cycle
//   a, b       operands
//   cin        carry-in to bit 0
//   sub        subtract select (PIPE_ADD_SUB_EN only)
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result
//   cout       carry out of bit WIDTH-1
module pipelined_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CHUNK_SAFE = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned STAGES     = WIDTH / CHUNK_SAFE;

  if ((CHUNK == 0) || (WIDTH == 0) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  logic w_en;
  logic r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic r_cout;

  // Single lockstep enable: the pipe advances unless a result is parked
  // at the output and is not being taken.
  assign w_en      = !r_out_vld || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_vld;
  assign sum       = r_sum;
  assign cout      = r_cout;

  // Stage k registers its inputs. These are the operand bits still to be
  // added (the low CHUNK bits are this stage's slice), the incoming carry,
  // and the sum slices already completed by the earlier stages.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM = WIDTH - k * CHUNK;

    logic             w_vld_nx;
    logic [REM-1:0]   w_a_nx;
    logic [REM-1:0]   w_b_nx;
    logic             w_c_nx;
    logic             w_sub_nx;
    logic [REM-1:0]   r_a_rem;
    logic [REM-1:0]   r_b_rem;
    logic             r_vld;
    logic             r_carry;
    logic             r_sub;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_add;
    logic [(k+1)*CHUNK-1:0] w_sum;

    if (k == 0) begin : g_port
      assign w_vld_nx = in_valid;
      assign w_a_nx   = a;
      assign w_b_nx   = b;
`ifdef PIPE_ADD_SUB_EN
      // Subtract inverts cin once on entry. b is inverted slice by slice
      // in each stage, using the staged sub bit.
      assign w_sub_nx = sub;
      assign w_c_nx   = cin ^ sub;
`else
      assign w_sub_nx = 1'b0;
      assign w_c_nx   = cin;
`endif
      assign w_sum    = w_add[CHUNK-1:0];
    end else begin : g_prev
      logic [k*CHUNK-1:0] r_sum_lo;

      assign w_vld_nx = g_stage[k-1].r_vld;
      assign w_a_nx   = g_stage[k-1].r_a_rem[REM+CHUNK-1:CHUNK];
      assign w_b_nx   = g_stage[k-1].r_b_rem[REM+CHUNK-1:CHUNK];
      assign w_c_nx   = g_stage[k-1].w_add[CHUNK];
      assign w_sub_nx = g_stage[k-1].r_sub;
      assign w_sum    = {w_add[CHUNK-1:0], r_sum_lo};

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum_lo <= '0;
        end else if (w_en) begin
          r_sum_lo <= g_stage[k-1].w_sum;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld   <= 1'b0;
        r_a_rem <= '0;
        r_b_rem <= '0;
        r_carry <= 1'b0;
        r_sub   <= 1'b0;
      end else if (w_en) begin
        r_vld   <= w_vld_nx;
        r_a_rem <= w_a_nx;
        r_b_rem <= w_b_nx;
        r_carry <= w_c_nx;
        r_sub   <= w_sub_nx;
      end
    end

`ifdef PIPE_ADD_SUB_EN
    assign w_b_chunk = r_b_rem[CHUNK-1:0] ^ {CHUNK{r_sub}};
`else
    assign w_b_chunk = r_b_rem[CHUNK-1:0];
`endif
    assign w_add = {1'b0, r_a_rem[CHUNK-1:0]} + {1'b0, w_b_chunk}
                 + {{CHUNK{1'b0}}, r_carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else if (w_en) begin
      r_out_vld <= g_stage[STAGES-1].r_vld;
      r_sum     <= g_stage[STAGES-1].w_sum;
      r_cout    <= g_stage[STAGES-1].w_add[CHUNK];
    end
  end

endmodule
